// File: rtl/sd_cmd_ctrl.sv
// sd_cmd_ctrl: SD card CMD-line controller (48-bit command out, optional 48-bit response in).
module sd_cmd_ctrl #(
  parameter int CLK_DIV      = 64,
  parameter int RESP_TIMEOUT = 64,
  parameter int GAP_CLKS     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_expect,
  output logic        done,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg,
  output logic        resp_crc_err,
  output logic        resp_timeout,
  output logic        sdio_clk,
  output logic        sdio_cmd_out,
  output logic        sdio_cmd_oe,
  input  logic        sdio_cmd_in
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND      = 3'd1;
  localparam logic [2:0] WAIT_RESP = 3'd2;
  localparam logic [2:0] RECV      = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;
  logic [2:0]  state;
  logic [7:0]  div_cnt;
  logic        tick;
  logic        fall;
  logic        rise;
  logic [15:0] cnt;
  logic [39:0] tx;
  logic [44:0] rx;
  logic [45:0] rx_next;
  logic [6:0]  crc;
  logic        expect_resp;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
  endfunction

  assign tick      = div_cnt == 8'(CLK_DIV - 1);
  assign fall      = tick & sdio_clk;
  assign rise      = tick & ~sdio_clk;
  assign rx_next   = {rx, sdio_cmd_in};
  assign cmd_ready = state == IDLE;

  // free-running card clock divider; ticks mark the cycle sdio_clk toggles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt  <= '0;
      sdio_clk <= 1'b0;
    end else begin
      div_cnt  <= tick ? 8'd0 : div_cnt + 8'd1;
      sdio_clk <= sdio_clk ^ tick;
    end

  // transaction sequencer: host bits leave on fall ticks, card bits are taken on rise ticks
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      tx           <= '0;
      rx           <= '0;
      crc          <= '0;
      expect_resp  <= 1'b0;
      sdio_cmd_out <= 1'b1;
      sdio_cmd_oe  <= 1'b0;
      done         <= 1'b0;
      resp_index   <= '0;
      resp_arg     <= '0;
      resp_crc_err <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          tx           <= {2'b01, cmd_index, cmd_arg};
          expect_resp  <= resp_expect;
          cnt          <= '0;
          crc          <= '0;
          resp_index   <= '0;
          resp_arg     <= '0;
          resp_crc_err <= 1'b0;
          resp_timeout <= 1'b0;
          state        <= SEND;
        end
        SEND: if (fall) begin
          if (cnt == 16'd48) begin
            sdio_cmd_oe  <= 1'b0;
            sdio_cmd_out <= 1'b1;
            crc          <= '0;
            cnt          <= '0;
            state        <= expect_resp ? WAIT_RESP : GAP;
          end else begin
            sdio_cmd_oe  <= 1'b1;
            sdio_cmd_out <= cnt < 16'd40 ? tx[39] : cnt < 16'd47 ? crc[6] : 1'b1;
            tx           <= {tx[38:0], 1'b0};
            crc          <= cnt < 16'd40 ? crc7_step(crc, tx[39]) : {crc[5:0], 1'b0};
            cnt          <= cnt + 16'd1;
          end
        end
        WAIT_RESP: if (rise) begin
          if (!sdio_cmd_in) begin
            rx    <= rx_next[44:0];
            crc   <= crc7_step(crc, 1'b0);
            cnt   <= 16'd1;
            state <= RECV;
          end else if (cnt == 16'(RESP_TIMEOUT - 1)) begin
            resp_timeout <= 1'b1;
            cnt          <= '0;
            state        <= GAP;
          end else
            cnt <= cnt + 16'd1;
        end
        RECV: if (rise) begin
          rx  <= rx_next[44:0];
          crc <= cnt < 16'd40 ? crc7_step(crc, sdio_cmd_in) : crc;
          cnt <= cnt + 16'd1;
          if (cnt == 16'd47) begin
            resp_index   <= rx_next[45:40];
            resp_arg     <= rx_next[39:8];
            resp_crc_err <= rx_next[7:1] != crc || !rx_next[0];
            cnt          <= '0;
            state        <= GAP;
          end
        end
        GAP: if (done)
          state <= IDLE;
        else if (rise && cnt == 16'(GAP_CLKS - 1))
          done <= 1'b1;
        else if (rise)
          cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// tb_sd_cmd_ctrl: vector table of commands with a card model and a result scoreboard.
module tb_sd_cmd_ctrl;
  localparam int CD = 4;
  localparam int RT = 64;
  localparam int GC = 8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        resp_expect = 1'b0;
  logic        done;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;
  logic        resp_crc_err;
  logic        resp_timeout;
  logic        sdio_clk;
  logic        sdio_cmd_out;
  logic        sdio_cmd_oe;
  logic        sdio_cmd_in = 1'b1;
  int          errors = 0;
  int          checks = 0;

  sd_cmd_ctrl #(.CLK_DIV(CD), .RESP_TIMEOUT(RT), .GAP_CLKS(GC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_expect(resp_expect), .done(done),
    .resp_index(resp_index), .resp_arg(resp_arg), .resp_crc_err(resp_crc_err),
    .resp_timeout(resp_timeout), .sdio_clk(sdio_clk), .sdio_cmd_out(sdio_cmd_out),
    .sdio_cmd_oe(sdio_cmd_oe), .sdio_cmd_in(sdio_cmd_in)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // mode: 0 no response, 1 good response, 2 arg bit flipped, 3 silent card, 4 bad end bit
  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        rexp;
    int          mode;
    logic [47:0] frame;
  } vec_t;

  typedef struct {
    logic [47:0] frame;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk(input logic [1:0] hdr, input logic [5:0] idx, input logic [31:0] arg);
    return {hdr, idx, arg, crc7({hdr, idx, arg}), 1'b1};
  endfunction

  task automatic wait_done(output int rises, output bit ok);
    logic prev;
    prev = sdio_clk;
    rises = 0;
    ok = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (sdio_clk && !prev) rises++;
      prev = sdio_clk;
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_oe(output bit ok);
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sdio_cmd_oe) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    exp_t g;
    logic [47:0] cap;
    logic [47:0] rw;
    logic oe_all;
    int rises;
    bit ok;
    e.frame = v.frame;
    e.idx = '0;
    e.arg = '0;
    e.err = 1'b0;
    e.to = 1'b0;
    rw = mk(2'b00, v.idx, v.arg);
    if (v.mode == 1 || v.mode == 2 || v.mode == 4) begin
      e.idx = v.idx;
      e.arg = v.arg;
    end
    if (v.mode == 2) begin
      rw[8] = ~rw[8];
      e.arg = v.arg ^ 32'h1;
      e.err = 1'b1;
    end
    if (v.mode == 3) e.to = 1'b1;
    if (v.mode == 4) begin
      rw[0] = 1'b0;
      e.err = 1'b1;
    end
    @(negedge clk);
    cmd_index = v.idx;
    cmd_arg = v.arg;
    resp_expect = v.rexp;
    cmd_valid = 1'b1;
    chk("ready_before_accept", cmd_ready, 1);
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ready_busy", cmd_ready, 0);
    chk("resp_cleared_at_accept", {resp_index, resp_arg, resp_crc_err, resp_timeout}, 0);
    wait_oe(ok);
    chk("oe_rises", ok, 1);
    oe_all = 1'b1;
    for (int i = 47; i >= 0; i--) begin
      @(posedge sdio_clk);
      #1;
      cap[i] = sdio_cmd_out;
      oe_all = oe_all & sdio_cmd_oe;
    end
    chk("oe_during_frame", oe_all, 1);
    @(negedge sdio_clk);
    #1;
    chk("oe_off_after_frame", {sdio_cmd_oe, sdio_cmd_out}, 2'b01);
    if (v.mode == 1 || v.mode == 2 || v.mode == 4) begin
      repeat (4) @(negedge sdio_clk);
      for (int i = 47; i >= 0; i--) begin
        @(negedge sdio_clk);
        #1;
        sdio_cmd_in = rw[i];
      end
      @(negedge sdio_clk);
      #1;
      sdio_cmd_in = 1'b1;
    end
    wait_done(rises, ok);
    chk("done_seen", ok, 1);
    if (v.mode == 0) chk("gap_rise_ticks", rises, GC);
    if (v.mode == 3) chk("timeout_rise_ticks", rises, RT + GC);
    chk("ready_low_at_done", cmd_ready, 0);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      g = sb.pop_front();
      chk("frame", cap, g.frame);
      chk("resp_index", resp_index, g.idx);
      chk("resp_arg", resp_arg, g.arg);
      chk("resp_crc_err", resp_crc_err, g.err);
      chk("resp_timeout", resp_timeout, g.to);
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", cmd_ready, 1);
    chk("resp_held", {resp_index, resp_arg, resp_crc_err, resp_timeout}, {g.idx, g.arg, g.err, g.to});
  endtask

  initial begin
    int acc;
    int rises;
    bit ok;
    vecs[0] = '{6'd0, 32'h0, 1'b0, 0, 48'h400000000095};
    vecs[1] = '{6'd8, 32'h000001AA, 1'b1, 1, 48'h48000001AA87};
    vecs[2] = '{6'd8, 32'h000001AA, 1'b1, 2, 48'h48000001AA87};
    vecs[3] = '{6'd55, 32'h0, 1'b1, 3, mk(2'b01, 6'd55, 32'h0)};
    vecs[4] = '{6'd17, 32'hDEADBEEF, 1'b1, 4, mk(2'b01, 6'd17, 32'hDEADBEEF)};
    vecs[5] = '{6'd63, 32'hFFFFFFFF, 1'b0, 0, mk(2'b01, 6'd63, 32'hFFFFFFFF)};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sdio_clk, sdio_cmd_out, sdio_cmd_oe, done}, 4'b0100);
    chk("reset_resp", {resp_index, resp_arg, resp_crc_err, resp_timeout}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", cmd_ready, 1);
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);
    @(negedge clk);
    cmd_index = 6'd0;
    cmd_arg = 32'h0;
    resp_expect = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_oe(ok);
    chk("midframe_oe", ok, 1);
    repeat (28) @(posedge sdio_clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_lines", {sdio_cmd_oe, sdio_cmd_out, sdio_clk}, 3'b010);
    chk("midframe_reset_state", {cmd_ready, done}, 2'b10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(vecs[0]);
    @(negedge clk);
    cmd_index = 6'd0;
    cmd_arg = 32'h0;
    resp_expect = 1'b0;
    cmd_valid = 1'b1;
    acc = cmd_ready ? 1 : 0;
    ok = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
      if (cmd_ready) acc++;
    end
    chk("held_valid_done", ok, 1);
    chk("held_valid_single_accept", acc, 1);
    chk("held_valid_ready_at_done", cmd_ready, 0);
    @(negedge clk);
    chk("held_valid_ready_next", cmd_ready, 1);
    @(negedge clk);
    chk("held_valid_second_accept", cmd_ready, 0);
    cmd_valid = 1'b0;
    wait_done(rises, ok);
    chk("held_valid_second_done", ok, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
